router_pkt_tx: RTL
==================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the 1x3 router input port. Buffers a payload, then sends one packet on pkt_valid/tx_data:
//  header {len[5:0],addr[1:0]}, payload bytes, then the parity byte with pkt_valid low. Stalls while busy is high.
//  Captures the router's err response for each packet and reports it. Used as a bridge or bench driver.
// PARAMETERS
//  BUF_DEPTH  64  payload buffer depth in bytes (power of 2, >= 63)
//  ERR_WAIT   3   cycles after the parity byte is accepted in which err is sampled
//  IDLE_GAP   2   minimum idle cycles between packets (pkt_valid low)
// PORTS
//  router_clock  in   1  single clock, rising edge
//  resetn        in   1  asynchronous, active-low reset
//  wr_en         in   1  push wr_data into the payload buffer (ignored when buf_full)
//  wr_data       in   8  payload byte
//  buf_full      out  1  payload buffer full
//  buf_count     out  7  bytes held in the payload buffer
//  start         in   1  packet request, sampled only when tx_ready=1
//  dest_addr     in   2  destination port 0..2
//  pld_len       in   6  payload length 1..63
//  tx_ready      out  1  IDLE and the gap has elapsed
//  start_rej     out  1  1-cycle pulse: request rejected
//  pkt_valid     out  1  to router pkt_valid
//  tx_data       out  8  to router data_in
//  busy          in   1  from router; 1 = hold the current byte
//  err           in   1  from router parity error
//  done          out  1  1-cycle pulse at packet completion
//  err_seen      out  1  valid with done: err was high during the sample window
// BEHAVIOUR
//  Reset (async): state IDLE, buffer emptied, gap counter 0.
//   All outputs 0 except tx_ready=1 and buf_count=0.
//  Byte acceptance: the byte on tx_data is accepted at a rising edge with busy=0 in HDR, PLD or PAR.
//   While busy=1, tx_data and pkt_valid hold unchanged.
//  FSM: IDLE -> HDR -> PLD -> PAR -> CHK -> GAP -> IDLE.
//  IDLE: start accepted only if dest_addr!=3, pld_len!=0 and buf_count>=pld_len.
//   Otherwise start_rej pulses for 1 cycle and the state stays IDLE.
//  Accepted start: latch addr/len. The next cycle enters HDR: pkt_valid=1, tx_data={len,addr}, parity reg=header.
//  HDR accepted -> PLD. tx_data = buffer head (first-word-fall-through). On each accept: pop, parity^=byte, cnt++.
//   The last payload byte accepted (cnt==len) -> PAR.
//  PAR: pkt_valid=0, tx_data=parity. Accepted (busy=0) -> CHK.
//  CHK: tx_data=0. Sample err for ERR_WAIT cycles; err_seen is the OR of the samples.
//   After the window: done=1 for 1 cycle -> GAP.
//  GAP: IDLE_GAP cycles with pkt_valid=0, then IDLE. tx_ready=1 only in IDLE.
//  Buffer: wr_en while full is dropped and has no effect. A push and a pop in the same cycle leave buf_count unchanged.
//   Pointers wrap modulo BUF_DEPTH.
//  Pushes during a packet are allowed. Bytes beyond len remain for the next packet.
//  Parity: 8-bit XOR of the header and all payload bytes. It excludes the parity byte itself.
//  Reset mid-packet: pkt_valid drops immediately; the partial packet is abandoned; no done pulse.
// CONFIGURATION
//  PARITY_CORRUPT_EN defined: adds input corrupt_par (1 bit), latched with start.
//   When set, the sent parity byte has bit 0 inverted.
//  PARITY_CORRUPT_EN undefined: the port is absent and parity is always correct.
// STRUCTURE
//  Shared package router_pkg: tx state encoding, ADDR_INVALID=2'd3, and header pack function hdr(len,addr).
//  Sub-module router_tx_buf: BUF_DEPTH x 8 synchronous FIFO, first-word-fall-through.
//   Ports: push, pop, din, dout, count, full, empty; same clock/reset.
//  FSM, counters, parity and err capture stay in router_pkt_tx.
// TESTING
//  Push 3 bytes 0x11,0x22,0x33; start addr=1 len=3, busy=0 ->
//   stream 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D (parity) with pkt_valid=0; done with err_seen=0.
//  Same stimulus with busy=1 for 2 cycles after the header ->
//   tx_data holds 0x11 and pkt_valid holds 1 for those cycles; the stream is otherwise identical.
//  Start with addr=3, or len=0, or len=5 with buf_count=2 -> start_rej pulse, pkt_valid stays 0, buf_count unchanged.
//  err forced high 2 cycles after the parity is accepted -> done with err_seen=1.
//   With PARITY_CORRUPT_EN and corrupt_par=1 -> parity byte is 0x0C.
//  Fill 64 bytes, wr_en again -> buf_count=64, the extra byte is dropped.
//   Then send len=63 -> buf_count=1, the remaining byte is the 64th written.
//  resetn low in PLD mid-packet -> pkt_valid=0 asynchronously, buf_count=0, tx_ready=1 after release, no done.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router input-port packet source.
// Holds the tx state encoding, the reserved address and the header packer.
package router_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PLD,
        S_PAR,
        S_CHK,
        S_GAP
    } tx_state_t;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    function automatic logic [7:0] hdr(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte FIFO, first-word-fall-through: dout always shows the head.
// Pushes while full and pops while empty are ignored.
module router_tx_buf #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: header, payload, parity, err capture.
// Define PARITY_CORRUPT_EN to add corrupt_par (flips parity bit 0 per packet).
import router_pkg::*;

module router_pkt_tx #(
    parameter int BUF_DEPTH = 64,
    parameter int ERR_WAIT  = 3,
    parameter int IDLE_GAP  = 2
) (
    input  logic                         router_clock,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         buf_full,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    input  logic                         start,
    input  logic [1:0]                   dest_addr,
    input  logic [5:0]                   pld_len,
    output logic                         tx_ready,
    output logic                         start_rej,
    output logic                         pkt_valid,
    output logic [7:0]                   tx_data,
    input  logic                         busy,
    input  logic                         err,
`ifdef PARITY_CORRUPT_EN
    input  logic                         corrupt_par,
`endif
    output logic                         done,
    output logic                         err_seen
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int WW = $clog2(ERR_WAIT + 1);
    localparam int GW = $clog2(IDLE_GAP + 1);

    tx_state_t     state;
    logic [5:0]    len_q;
    logic [5:0]    cnt;
    logic [7:0]    parity;
    logic [7:0]    tx_reg;
    logic [7:0]    head;
    logic [WW-1:0] wcnt;
    logic [GW-1:0] gcnt;
    logic          err_acc;
    logic          cpar;
    logic          pop;
    logic          buf_empty;
    logic          start_ok;

    router_tx_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk   (router_clock),
        .rst_n (resetn),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign start_ok = (dest_addr != ADDR_INVALID) && (pld_len != 6'd0)
                   && (buf_count >= CW'(pld_len));
    assign pop      = (state == S_PLD) && !busy && !buf_empty;
    // Payload bytes come straight from the FIFO head so a pop lands on accept.
    assign tx_data  = (state == S_PLD) ? head : tx_reg;

`ifdef PARITY_CORRUPT_EN
    always_ff @(posedge router_clock or negedge resetn) begin
        if (!resetn) begin
            cpar <= 1'b0;
        end else if (state == S_IDLE && start && start_ok) begin
            cpar <= corrupt_par;
        end
    end
`else
    assign cpar = 1'b0;
`endif

    always_ff @(posedge router_clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            parity    <= '0;
            tx_reg    <= '0;
            wcnt      <= '0;
            gcnt      <= '0;
            err_acc   <= 1'b0;
            pkt_valid <= 1'b0;
            tx_ready  <= 1'b1;
            start_rej <= 1'b0;
            done      <= 1'b0;
            err_seen  <= 1'b0;
        end else begin
            start_rej <= 1'b0;
            done      <= 1'b0;
            err_seen  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && start_ok) begin
                        state     <= S_HDR;
                        len_q     <= pld_len;
                        cnt       <= '0;
                        pkt_valid <= 1'b1;
                        tx_reg    <= hdr(pld_len, dest_addr);
                        parity    <= hdr(pld_len, dest_addr);
                        tx_ready  <= 1'b0;
                    end else if (start) begin
                        start_rej <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        state <= S_PLD;
                    end
                end
                S_PLD: begin
                    if (pop) begin
                        parity <= parity ^ head;
                        cnt    <= cnt + 6'd1;
                        if (cnt + 6'd1 == len_q) begin
                            state     <= S_PAR;
                            pkt_valid <= 1'b0;
                            tx_reg    <= parity ^ head ^ {7'd0, cpar};
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        state   <= S_CHK;
                        tx_reg  <= '0;
                        wcnt    <= '0;
                        err_acc <= 1'b0;
                    end
                end
                S_CHK: begin
                    err_acc <= err_acc | err;
                    wcnt    <= wcnt + WW'(1);
                    if (wcnt == WW'(ERR_WAIT - 1)) begin
                        done     <= 1'b1;
                        err_seen <= err_acc | err;
                        state    <= S_GAP;
                        gcnt     <= '0;
                    end
                end
                S_GAP: begin
                    if (gcnt == GW'(IDLE_GAP - 1)) begin
                        state    <= S_IDLE;
                        tx_ready <= 1'b1;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
